line_clear_ctrl: RTL and testbench

//  Sequences the 10x20 1-bit board memory after a piece locks. Scans rows from bottom (y=19)
//  to top and removes every full row. Shifts surviving rows down and zero-fills the vacated top rows.

---
 rtl/line_clear_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board bottom-up, drops full rows, compacts the rest, zero-fills the top.
// Optional LINE_CLEAR_STATS_EN adds a saturating lifetime total_lines counter.
module line_clear_ctrl #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int RD_LAT = 1,
  localparam int XW    = $clog2(COLS),
  localparam int YW    = $clog2(ROWS)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    lines_cleared,
`ifdef LINE_CLEAR_STATS_EN
  output logic [15:0]   total_lines,
`endif
  output logic [XW-1:0] board_rx,
  output logic [YW-1:0] board_ry,
  input  logic          board_rdata,
  output logic          board_we,
  output logic [XW-1:0] board_wx,
  output logic [YW-1:0] board_wy,
  output logic          board_wdata
);

  localparam int CW = $clog2(COLS + RD_LAT + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(COLS + RD_LAT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] COLS_C   = CW'(COLS);
  localparam logic [CW-1:0] LAT_C    = CW'(RD_LAT);
  localparam logic [YW:0]   ROW_TOP  = (YW+1)'(ROWS - 1);
  localparam logic [YW:0]   ROW_ONE  = (YW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_COPY, S_FILL, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [YW:0]   r_src, r_dst, w_src_next, w_dst_next, w_src_dec, w_dst_dec;
  logic          w_src_uflow, w_dst_uflow;
  logic [CW-1:0] r_col, w_col_next, w_cap_idx;
  logic [COLS-1:0] r_rowbuf, w_rowbuf_next;
  logic [2:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic [2:0]    r_lines, w_lines_next;

  // Row indices carry one extra bit: its MSB set after a decrement means we went below row 0.
  assign w_src_dec   = r_src - ROW_ONE;
  assign w_dst_dec   = r_dst - ROW_ONE;
  assign w_src_uflow = w_src_dec[YW];
  assign w_dst_uflow = w_dst_dec[YW];
  assign w_cap_idx   = r_col - LAT_C;
  assign w_cnt_inc   = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;

  assign lines_cleared = r_lines;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_col    <= '0;
      r_rowbuf <= '0;
      r_cnt    <= '0;
      r_lines  <= '0;
    end else begin
      r_src    <= w_src_next;
      r_dst    <= w_dst_next;
      r_col    <= w_col_next;
      r_rowbuf <= w_rowbuf_next;
      r_cnt    <= w_cnt_next;
      r_lines  <= w_lines_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_src_next    = r_src;
    w_dst_next    = r_dst;
    w_col_next    = r_col;
    w_rowbuf_next = r_rowbuf;
    w_cnt_next    = r_cnt;
    w_lines_next  = r_lines;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    board_rx      = '0;
    board_ry      = '0;
    board_we      = 1'b0;
    board_wx      = '0;
    board_wy      = '0;
    board_wdata   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_READ;
          w_src_next   = ROW_TOP;
          w_dst_next   = ROW_TOP;
          w_col_next   = '0;
          w_cnt_next   = '0;
          w_lines_next = '0;
        end
      end
      S_READ: begin
        board_ry = r_src[YW-1:0];
        if (r_col < COLS_C) board_rx = r_col[XW-1:0];
        if (r_col >= LAT_C) w_rowbuf_next[w_cap_idx[XW-1:0]] = board_rdata;
        if (r_col == RD_LAST) begin
          w_col_next   = '0;
          w_state_next = S_EVAL;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
      S_EVAL: begin
        if (&r_rowbuf) begin
          // cnt is nonzero after this increment, so running off the top always needs a fill.
          w_cnt_next   = w_cnt_inc;
          w_src_next   = w_src_dec;
          w_state_next = w_src_uflow ? S_FILL : S_READ;
        end else if (r_src != r_dst) begin
          w_state_next = S_COPY;
        end else begin
          w_src_next   = w_src_dec;
          w_dst_next   = w_dst_dec;
          w_state_next = w_src_uflow ? ((r_cnt != 3'd0) ? S_FILL : S_DONE) : S_READ;
        end
      end
      S_COPY: begin
        board_we    = 1'b1;
        board_wy    = r_dst[YW-1:0];
        board_wx    = r_col[XW-1:0];
        board_wdata = r_rowbuf[r_col[XW-1:0]];
        if (r_col == COL_LAST) begin
          w_col_next   = '0;
          w_src_next   = w_src_dec;
          w_dst_next   = w_dst_dec;
          w_state_next = w_src_uflow ? ((r_cnt != 3'd0) ? S_FILL : S_DONE) : S_READ;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
      S_FILL: begin
        board_we = 1'b1;
        board_wy = r_dst[YW-1:0];
        board_wx = r_col[XW-1:0];
        if (r_col == COL_LAST) begin
          w_col_next   = '0;
          w_dst_next   = w_dst_dec;
          w_state_next = w_dst_uflow ? S_DONE : S_FILL;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Publish the count as DONE is entered so it is already valid while done is high.
    if (w_state_next == S_DONE && r_state != S_DONE) w_lines_next = w_cnt_next;
  end

`ifdef LINE_CLEAR_STATS_EN
  logic [15:0] r_total;
  logic [16:0] w_total_sum;

  assign w_total_sum = {1'b0, r_total} + {14'd0, r_cnt};
  assign total_lines = r_total;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                 r_total <= '0;
    else if (r_state == S_DONE) r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized bench for line_clear_ctrl: board RAM model plus a row-survivor reference model.
module tb_line_clear_ctrl;
  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int RD_LAT = 1;
  localparam int XW     = 4;
  localparam int YW     = 5;
  localparam int BOUND  = 3000;

  logic          CLOCK_50, reset, start, busy, done;
  logic [2:0]    lines_cleared;
  logic [XW-1:0] board_rx, board_wx;
  logic [YW-1:0] board_ry, board_wy;
  logic          board_rdata, board_we, board_wdata;
`ifdef LINE_CLEAR_STATS_EN
  logic [15:0]   total_lines;
  int            exp_total;
`endif

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(RD_LAT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared),
`ifdef LINE_CLEAR_STATS_EN
    .total_lines(total_lines),
`endif
    .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
    .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata)
  );

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic [COLS-1:0] exp_board [ROWS];
  logic            rd_pipe [RD_LAT];
  logic            load_en;
  int              exp_lines, exp_cycles;
  int              tests, fails;
  bit              chk_en;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Board RAM: bulk load from img, one-cell write port, RD_LAT-deep registered read.
  always @(posedge CLOCK_50) begin
    if (load_en) begin
      for (int y = 0; y < ROWS; y++) mem[y] <= img[y];
    end else if (board_we) begin
      mem[board_wy][board_wx] <= board_wdata;
    end
    rd_pipe[0] <= mem[board_ry][board_rx];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign board_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Surviving rows, taken bottom-up, stack from row ROWS-1 upward; the rest become empty.
  task automatic model();
    int q[$];
    int copied;
    copied    = 0;
    exp_lines = 0;
    for (int y = ROWS - 1; y >= 0; y--) begin
      if (&img[y]) exp_lines++;
      else q.push_back(y);
    end
    for (int i = 0; i < ROWS; i++) begin
      int d;
      d = ROWS - 1 - i;
      if (i < q.size()) begin
        exp_board[d] = img[q[i]];
        if (q[i] != d) copied++;
      end else begin
        exp_board[d] = '0;
      end
    end
    exp_cycles = ROWS * (COLS + RD_LAT + 1) + COLS * (copied + exp_lines) + 1;
  endtask

  // Every write must carry the final value of that cell; nothing is written when no row is full.
  always @(negedge CLOCK_50) begin
    if (!reset && chk_en) begin
      if (board_we) begin
        check("write_data", int'(board_wdata), int'(exp_board[board_wy][board_wx]));
        check("write_allowed", int'(exp_lines != 0), 1);
        check("raddr_during_write", int'({board_ry, board_rx}), 0);
      end else begin
        check("wdata_without_we", int'(board_wdata), 0);
      end
      if (!busy) begin
        check("we_when_idle", int'(board_we), 0);
        check("raddr_when_idle", int'({board_ry, board_rx}), 0);
      end
    end
  end

  task automatic load_img();
    load_en = 1'b1;
    @(posedge CLOCK_50);
    #1 load_en = 1'b0;
  endtask

  task automatic gen_random();
    int nfull;
    int r;
    logic [31:0] v;
    nfull = 0;
    for (int y = 0; y < ROWS; y++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2 && nfull < 6) begin
        img[y] = '1;
        nfull++;
      end else if (r < 4) begin
        img[y] = '0;
      end else begin
        v = $urandom;
        img[y] = v[COLS-1:0];
        if (&img[y]) img[y][0] = 1'b0;
      end
    end
  endtask

  task automatic run_pass(input string name, input bit extra_start,
                          output int cyc, output int ndone, output int lines_at_done);
    int i;
    int rowbad;
    model();
    load_img();
    chk_en = 1'b1;
    @(negedge CLOCK_50) start = 1'b1;
    @(negedge CLOCK_50) start = 1'b0;
    cyc = 0; ndone = 0; lines_at_done = -1; i = 0;
    while (busy && i < BOUND) begin
      cyc++;
      if (done) begin
        ndone++;
        lines_at_done = int'(lines_cleared);
      end
      if (extra_start) start = (i == 4 || i == 150);
      @(negedge CLOCK_50);
      i++;
    end
    start = 1'b0;
    check({name, "_no_timeout"}, int'(i < BOUND), 1);
    check({name, "_busy_cycles"}, cyc, exp_cycles);
    check({name, "_done_pulses"}, ndone, 1);
    check({name, "_lines_at_done"}, lines_at_done, exp_lines);
    check({name, "_lines_held"}, int'(lines_cleared), exp_lines);
    rowbad = 0;
    for (int y = 0; y < ROWS; y++) if (mem[y] !== exp_board[y]) rowbad++;
    check({name, "_rows_wrong"}, rowbad, 0);
`ifdef LINE_CLEAR_STATS_EN
    exp_total = (exp_total + exp_lines > 65535) ? 65535 : exp_total + exp_lines;
    check({name, "_total_lines"}, int'(total_lines), exp_total);
`endif
    $display("[TB] pass %s: lines=%0d busy_cycles=%0d", name, lines_at_done, cyc);
    chk_en = 1'b0;
  endtask

  initial begin
    int cyc, nd, ln, i;
    tests = 0; fails = 0; chk_en = 1'b0;
    start = 1'b0; load_en = 1'b0; reset = 1'b1;
`ifdef LINE_CLEAR_STATS_EN
    exp_total = 0;
`endif
    for (int y = 0; y < ROWS; y++) img[y] = '0;
    repeat (2) @(negedge CLOCK_50);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_we", int'(board_we), 0);
    check("reset_wdata", int'(board_wdata), 0);
    check("reset_addr", int'({board_rx, board_ry, board_wx, board_wy}), 0);
    check("reset_lines", int'(lines_cleared), 0);
    reset = 1'b0;

    // Empty board: 20 x (10+1+1) + 1 busy cycles, no writes.
    run_pass("empty", 1'b0, cyc, nd, ln);
    check("empty_cycles_literal", cyc, 241);
    check("empty_lines_literal", ln, 0);

    img[19] = '1; img[18] = 10'b1000000001;
    run_pass("one_line", 1'b0, cyc, nd, ln);
    check("one_line_lines_literal", ln, 1);
    check("one_line_row19", int'(mem[19]), int'(10'b1000000001));
    check("one_line_row18", int'(mem[18]), 0);

    for (int y = 0; y < ROWS; y++) img[y] = '0;
    for (int y = 16; y < ROWS; y++) img[y] = '1;
    img[15] = 10'b0000010000;
    run_pass("tetris", 1'b0, cyc, nd, ln);
    check("tetris_lines_literal", ln, 4);
    check("tetris_row19", int'(mem[19]), int'(10'b0000010000));
    check("tetris_row18", int'(mem[18]), 0);

    for (int y = 0; y < ROWS; y++) img[y] = '0;
    img[19] = '1; img[18] = 10'b0011001100; img[17] = '1; img[16] = 10'b1100000011;
    img[5] = 10'b0000000001;
    run_pass("split", 1'b0, cyc, nd, ln);
    check("split_lines_literal", ln, 2);
    check("split_row19", int'(mem[19]), int'(10'b0011001100));
    check("split_row18", int'(mem[18]), int'(10'b1100000011));
    check("split_row17", int'(mem[17]), 0);
    check("split_row7", int'(mem[7]), 1);

    // A second start while busy must not change the pass.
    gen_random();
    img[19] = '1;
    run_pass("start_while_busy", 1'b1, cyc, nd, ln);

    for (int n = 0; n < 12; n++) begin
      gen_random();
      run_pass($sformatf("rand%0d", n), 1'b0, cyc, nd, ln);
    end

    // Reset in the middle of a COPY: everything drops at once and no done follows.
    for (int y = 0; y < ROWS; y++) img[y] = '0;
    img[19] = '1; img[18] = 10'b0101010101; img[10] = 10'b1110000000;
    model();
    load_img();
    @(negedge CLOCK_50) start = 1'b1;
    @(negedge CLOCK_50) start = 1'b0;
    i = 0;
    while (!board_we && i < BOUND) begin
      @(negedge CLOCK_50);
      i++;
    end
    check("reset_test_reached_copy", int'(board_we), 1);
    #2 reset = 1'b1;
    #1;
    check("midpass_reset_busy", int'(busy), 0);
    check("midpass_reset_we", int'(board_we), 0);
    check("midpass_reset_done", int'(done), 0);
    check("midpass_reset_lines", int'(lines_cleared), 0);
    @(negedge CLOCK_50) reset = 1'b0;
`ifdef LINE_CLEAR_STATS_EN
    exp_total = 0;
    check("midpass_reset_total", int'(total_lines), 0);
`endif
    nd = 0; cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK_50);
      if (done) nd++;
      if (busy) cyc++;
    end
    check("after_reset_no_done", nd, 0);
    check("after_reset_not_busy", cyc, 0);
    $display("[TB] pass mid_copy_reset: aborted");

    gen_random();
    run_pass("after_reset", 1'b0, cyc, nd, ln);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
